branch_update_scheduler: RTL and testbench

BRANCH_UPDATE_SCHEDULER -- requirements
Module: branch_update_scheduler

---
 rtl/branch_update_scheduler.sv | 177 +++++++++++++++++
 tb/tb_branch_update_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_update_scheduler.sv
// branch_update_scheduler
//   Tracks predicted branches in flight between fetch and resolution. Entries
//   {pc, history, prediction} are kept in an in-order circular queue. Each
//   resolve of the oldest entry produces a one-cycle predictor write strobe.
//   A wrong prediction also produces a one-cycle mispredict pulse with the
//   corrected global history, flushes the queue and blocks allocation for one
//   cycle (RECOVER state).
//
// Optional feature: define BUS_MISPREDICT_STATS_EN to add a saturating 16-bit
// mispredict counter output (mispredict_count_o).
//
// Ports
//   clk                  system clock, rising edge
//   reset                asynchronous, active-high reset
//   alloc_valid_i        fetch allocates a predicted branch
//   alloc_pc_i           16 PC bits of the allocated branch
//   alloc_history_i      history snapshot used at prediction
//   alloc_prediction_i   predicted direction
//   alloc_ready_o        entry can be accepted this cycle
//   resolve_valid_i      oldest in-flight branch resolved this cycle
//   resolve_outcome_i    actual direction (1 = taken)
//   upd_write_enabled_o  one-cycle predictor write strobe
//   upd_pc_o             PC for predictor write
//   upd_history_o        history for predictor write index
//   upd_outcome_o        outcome for predictor write
//   mispredict_o         one-cycle redirect pulse
//   recover_history_o    corrected (or speculative) global history
//   occupancy_o          current entry count
//   mispredict_count_o   mispredict counter (BUS_MISPREDICT_STATS_EN only)

module branch_update_scheduler #(
    parameter int unsigned HISTORY_LEN = 8,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_valid_i,
    input  logic [15:0]              alloc_pc_i,
    input  logic [HISTORY_LEN-1:0]   alloc_history_i,
    input  logic                     alloc_prediction_i,
    output logic                     alloc_ready_o,
    input  logic                     resolve_valid_i,
    input  logic                     resolve_outcome_i,
    output logic                     upd_write_enabled_o,
    output logic [15:0]              upd_pc_o,
    output logic [HISTORY_LEN-1:0]   upd_history_o,
    output logic                     upd_outcome_o,
    output logic                     mispredict_o,
    output logic [HISTORY_LEN-1:0]   recover_history_o,
    output logic [$clog2(DEPTH):0]   occupancy_o
`ifdef BUS_MISPREDICT_STATS_EN
    ,
    output logic [15:0]              mispredict_count_o
`endif
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned OccW = PtrW + 1;

    typedef enum logic [0:0] {StActive, StRecover} state_e;

    state_e                 state_q, state_d;
    logic [PtrW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [OccW-1:0]        occ_q, occ_d;

    logic [15:0]            pc_mem_q   [DEPTH];
    logic [HISTORY_LEN-1:0] hist_mem_q [DEPTH];
    logic                   pred_mem_q [DEPTH];

    logic                   upd_we_q;
    logic [15:0]            upd_pc_q;
    logic [HISTORY_LEN-1:0] upd_hist_q;
    logic                   upd_outcome_q;
    logic                   mispredict_q;
    logic [HISTORY_LEN-1:0] rec_hist_q, rec_hist_d;

    logic alloc_fire, resolve_fire, mispredict_hit, alloc_write;

    // Readiness uses registered occupancy only: a full queue blocks allocation
    // even when the head resolves in the same cycle.
    assign alloc_ready_o  = (state_q == StActive) && (occ_q < OccW'(DEPTH));
    assign alloc_fire     = alloc_valid_i && alloc_ready_o;
    assign resolve_fire   = resolve_valid_i && (occ_q != '0);
    assign mispredict_hit = resolve_fire && (resolve_outcome_i != pred_mem_q[head_q]);
    // A mispredict flushes the queue, including a same-cycle allocation.
    assign alloc_write    = alloc_fire && !mispredict_hit;

    always_comb begin
        state_d    = StActive;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        rec_hist_d = rec_hist_q;

        if (mispredict_hit) begin
            state_d    = StRecover;
            head_d     = '0;
            tail_d     = '0;
            occ_d      = '0;
            rec_hist_d = {hist_mem_q[head_q][HISTORY_LEN-2:0], resolve_outcome_i};
        end else begin
            if (resolve_fire) begin
                head_d = head_q + PtrW'(1);
            end
            if (alloc_write) begin
                tail_d     = tail_q + PtrW'(1);
                // Speculative history tracks the youngest allocated branch.
                rec_hist_d = {alloc_history_i[HISTORY_LEN-2:0], alloc_prediction_i};
            end
            if (alloc_write && !resolve_fire) begin
                occ_d = occ_q + OccW'(1);
            end else if (!alloc_write && resolve_fire) begin
                occ_d = occ_q - OccW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StActive;
            head_q        <= '0;
            tail_q        <= '0;
            occ_q         <= '0;
            upd_we_q      <= 1'b0;
            upd_pc_q      <= '0;
            upd_hist_q    <= '0;
            upd_outcome_q <= 1'b0;
            mispredict_q  <= 1'b0;
            rec_hist_q    <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            occ_q        <= occ_d;
            upd_we_q     <= resolve_fire;
            mispredict_q <= mispredict_hit;
            rec_hist_q   <= rec_hist_d;
            if (resolve_fire) begin
                upd_pc_q      <= pc_mem_q[head_q];
                upd_hist_q    <= hist_mem_q[head_q];
                upd_outcome_q <= resolve_outcome_i;
            end
        end
    end

    // Entry storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (alloc_write) begin
            pc_mem_q[tail_q]   <= alloc_pc_i;
            hist_mem_q[tail_q] <= alloc_history_i;
            pred_mem_q[tail_q] <= alloc_prediction_i;
        end
    end

`ifdef BUS_MISPREDICT_STATS_EN
    logic [15:0] mp_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mp_count_q <= '0;
        end else if (mispredict_hit && (mp_count_q != 16'hFFFF)) begin
            mp_count_q <= mp_count_q + 16'd1;
        end
    end

    assign mispredict_count_o = mp_count_q;
`endif

    assign upd_write_enabled_o = upd_we_q;
    assign upd_pc_o            = upd_pc_q;
    assign upd_history_o       = upd_hist_q;
    assign upd_outcome_o       = upd_outcome_q;
    assign mispredict_o        = mispredict_q;
    assign recover_history_o   = rec_hist_q;
    assign occupancy_o         = occ_q;

endmodule

// File: tb/tb_branch_update_scheduler.sv
module tb_branch_update_scheduler;

    localparam int unsigned HL = 8;
    localparam int unsigned DP = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          alloc_valid_i = 1'b0;
    logic [15:0]   alloc_pc_i = '0;
    logic [HL-1:0] alloc_history_i = '0;
    logic          alloc_prediction_i = 1'b0;
    logic          alloc_ready_o;
    logic          resolve_valid_i = 1'b0;
    logic          resolve_outcome_i = 1'b0;
    logic          upd_write_enabled_o;
    logic [15:0]   upd_pc_o;
    logic [HL-1:0] upd_history_o;
    logic          upd_outcome_o;
    logic          mispredict_o;
    logic [HL-1:0] recover_history_o;
    logic [2:0]    occupancy_o;
`ifdef BUS_MISPREDICT_STATS_EN
    logic [15:0]   mispredict_count_o;
`endif

    branch_update_scheduler #(
        .HISTORY_LEN(HL),
        .DEPTH      (DP)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .alloc_valid_i      (alloc_valid_i),
        .alloc_pc_i         (alloc_pc_i),
        .alloc_history_i    (alloc_history_i),
        .alloc_prediction_i (alloc_prediction_i),
        .alloc_ready_o      (alloc_ready_o),
        .resolve_valid_i    (resolve_valid_i),
        .resolve_outcome_i  (resolve_outcome_i),
        .upd_write_enabled_o(upd_write_enabled_o),
        .upd_pc_o           (upd_pc_o),
        .upd_history_o      (upd_history_o),
        .upd_outcome_o      (upd_outcome_o),
        .mispredict_o       (mispredict_o),
        .recover_history_o  (recover_history_o),
`ifdef BUS_MISPREDICT_STATS_EN
        .mispredict_count_o (mispredict_count_o),
`endif
        .occupancy_o        (occupancy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          alloc;
        logic [15:0]   pc;
        logic [HL-1:0] hist;
        logic          pred;
        logic          res;
        logic          outcome;
        int            exp_occ;
        logic          exp_ready;
    } vec_t;

    typedef struct {
        logic [15:0]   pc;
        logic [HL-1:0] hist;
        logic          pred;
    } ent_t;

    typedef struct {
        logic [15:0]   pc;
        logic [HL-1:0] hist;
        logic          outcome;
        logic          mp;
        logic [HL-1:0] rh;
    } upd_t;

    int n_checks = 0;
    int n_fail   = 0;

    ent_t          model_q[$];
    upd_t          sb[$];
    logic          model_rec = 1'b0;
    logic [HL-1:0] exp_rh = '0;
    vec_t          vecs[$];

    function automatic vec_t mk(input logic a, input logic [15:0] pc, input logic [HL-1:0] h,
                                input logic p, input logic r, input logic o, input int occ,
                                input logic rdy);
        vec_t v;
        v.alloc = a; v.pc = pc; v.hist = h; v.pred = p;
        v.res = r; v.outcome = o; v.exp_occ = occ; v.exp_ready = rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        model_q.delete();
        sb.delete();
        model_rec = 1'b0;
        exp_rh    = '0;
    endtask

    // Drive one cycle from the negative edge, update the model, check at the next negedge.
    task automatic step(input vec_t v);
        logic rdy, res_ok, mp;
        ent_t h;
        ent_t e;
        upd_t u;
        alloc_valid_i      = v.alloc;
        alloc_pc_i         = v.pc;
        alloc_history_i    = v.hist;
        alloc_prediction_i = v.pred;
        resolve_valid_i    = v.res;
        resolve_outcome_i  = v.outcome;

        rdy       = !model_rec && (model_q.size() < DP);
        res_ok    = v.res && (model_q.size() > 0);
        mp        = 1'b0;
        model_rec = 1'b0;
        h         = '{pc: '0, hist: '0, pred: 1'b0};
        if (res_ok) begin
            h  = model_q.pop_front();
            mp = (v.outcome != h.pred);
            if (mp) begin
                exp_rh = {h.hist[HL-2:0], v.outcome};
                model_q.delete();
                model_rec = 1'b1;
            end
        end
        if (rdy && v.alloc && !mp) begin
            e = '{pc: v.pc, hist: v.hist, pred: v.pred};
            model_q.push_back(e);
            exp_rh = {v.hist[HL-2:0], v.pred};
        end
        if (res_ok) begin
            u = '{pc: h.pc, hist: h.hist, outcome: v.outcome, mp: mp, rh: exp_rh};
            sb.push_back(u);
        end

        @(posedge clk);
        @(negedge clk);
        alloc_valid_i   = 1'b0;
        resolve_valid_i = 1'b0;

        chk("occupancy", 32'(occupancy_o), 32'(v.exp_occ));
        chk("alloc_ready", 32'(alloc_ready_o), 32'(v.exp_ready));
        chk("recover_history", 32'(recover_history_o), 32'(exp_rh));
        if (sb.size() > 0) begin
            u = sb.pop_front();
            chk("upd_write_enabled", 32'(upd_write_enabled_o), 32'd1);
            chk("upd_pc", 32'(upd_pc_o), 32'(u.pc));
            chk("upd_history", 32'(upd_history_o), 32'(u.hist));
            chk("upd_outcome", 32'(upd_outcome_o), 32'(u.outcome));
            chk("mispredict", 32'(mispredict_o), 32'(u.mp));
        end else begin
            chk("upd_write_enabled_idle", 32'(upd_write_enabled_o), 32'd0);
            chk("mispredict_idle", 32'(mispredict_o), 32'd0);
        end
    endtask

    task automatic check_reset_values();
        chk("rst_occupancy", 32'(occupancy_o), 32'd0);
        chk("rst_alloc_ready", 32'(alloc_ready_o), 32'd1);
        chk("rst_upd_we", 32'(upd_write_enabled_o), 32'd0);
        chk("rst_upd_pc", 32'(upd_pc_o), 32'd0);
        chk("rst_upd_history", 32'(upd_history_o), 32'd0);
        chk("rst_upd_outcome", 32'(upd_outcome_o), 32'd0);
        chk("rst_mispredict", 32'(mispredict_o), 32'd0);
        chk("rst_recover_history", 32'(recover_history_o), 32'd0);
`ifdef BUS_MISPREDICT_STATS_EN
        chk("rst_mispredict_count", 32'(mispredict_count_o), 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b1;
        #1;
        check_reset_values();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();

        // Basic alloc/resolve, empty resolve, fill/drop, drain
        vecs.push_back(mk(1, 16'h0010, 8'h00, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 0, 1, 1, 0, 1));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 0, 1, 0, 0, 1));
        vecs.push_back(mk(1, 16'h0100, 8'h11, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 16'h0101, 8'h22, 0, 0, 0, 2, 1));
        vecs.push_back(mk(1, 16'h0102, 8'h33, 1, 0, 0, 3, 1));
        vecs.push_back(mk(1, 16'h0103, 8'h44, 0, 0, 0, 4, 0));
        vecs.push_back(mk(1, 16'h0104, 8'h55, 1, 0, 0, 4, 0));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 0, 1, 1, 3, 1));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 0, 1, 0, 2, 1));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 0, 1, 0, 0, 1));
        // Mispredict with a same-cycle allocation that must be discarded
        vecs.push_back(mk(1, 16'h0200, 8'h5A, 0, 0, 0, 1, 1));
        vecs.push_back(mk(1, 16'h0201, 8'h12, 1, 0, 0, 2, 1));
        vecs.push_back(mk(1, 16'h0202, 8'h34, 1, 0, 0, 3, 1));
        vecs.push_back(mk(1, 16'h0203, 8'h77, 1, 1, 1, 0, 0));
        vecs.push_back(mk(1, 16'h0300, 8'h00, 0, 0, 0, 0, 1));
        // Six alloc/resolve pairs across the pointer wrap
        vecs.push_back(mk(1, 16'h0400, 8'h01, 1, 0, 0, 1, 1));
        vecs.push_back(mk(1, 16'h0401, 8'h02, 0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 16'h0402, 8'h03, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1, 16'h0403, 8'h04, 0, 1, 1, 1, 1));
        vecs.push_back(mk(1, 16'h0404, 8'h05, 1, 1, 0, 1, 1));
        vecs.push_back(mk(1, 16'h0405, 8'h06, 0, 1, 1, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 0, 1, 0, 0, 1));
        // Mispredict the other way (predicted taken, not taken)
        vecs.push_back(mk(1, 16'h0450, 8'hC3, 1, 0, 0, 1, 1));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i]);
        end

        // Reset mid-operation with a resolve pending before the edge
        step(mk(1, 16'h0600, 8'h21, 1, 0, 0, 1, 1));
        step(mk(1, 16'h0601, 8'h22, 0, 0, 0, 2, 1));
        resolve_valid_i   = 1'b1;
        resolve_outcome_i = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_values();
        model_clear();
        @(negedge clk);
        resolve_valid_i = 1'b0;
        reset = 1'b0;
        step(mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1));
        step(mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1));

`ifdef BUS_MISPREDICT_STATS_EN
        for (int k = 0; k < 3; k++) begin
            step(mk(1, 16'h0500 + 16'(k), 8'h0F, 1, 0, 0, 1, 1));
            step(mk(0, 16'h0000, 8'h00, 0, 1, 0, 0, 0));
            step(mk(0, 16'h0000, 8'h00, 0, 0, 0, 0, 1));
        end
        chk("mispredict_count", 32'(mispredict_count_o), 32'd3);
        step(mk(1, 16'h0700, 8'h01, 1, 0, 0, 1, 1));
        step(mk(1, 16'h0701, 8'h02, 1, 0, 0, 2, 1));
        reset = 1'b1;
        #1;
        chk("count_after_reset", 32'(mispredict_count_o), 32'd0);
        chk("occ_after_reset", 32'(occupancy_o), 32'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
